wb_cw_arbiter: RTL and testbench

- Two-master arbiter sharing the single 16-bit wishbone port that feeds the cross-clock/compressor path of the upper core.
- Master 0 is the upper core bus. Master 1 is a secondary requester, such as a debug/LA-driven or DMA master.
- Grants by round-robin and holds the grant for the whole cycle, including 4/8-beat bursts.
- Watchdog terminates stalled transfers with err.

---
 rtl/wb_cw_arbiter.sv | 136 +++++++++++++
 tb/tb_wb_cw_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cw_arbiter.sv
// Two-master round-robin Wishbone arbiter for the 16-bit cross-clock/compressor port.
// The grant is held for the whole cycle (bursts included); a watchdog ends stalled beats with err.
module wb_cw_arbiter #(
  parameter int WB_ADDR_W   = 24,
  parameter int WB_DATA_W   = 16,
  parameter int WB_SEL_BITS = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   m0_wb_cyc,
  input  logic                   m0_wb_stb,
  input  logic                   m0_wb_we,
  input  logic [WB_ADDR_W-1:0]   m0_wb_adr,
  input  logic [WB_DATA_W-1:0]   m0_wb_o_dat,
  input  logic [WB_SEL_BITS-1:0] m0_wb_sel,
  input  logic                   m0_wb_4_burst,
  input  logic                   m0_wb_8_burst,
  output logic [WB_DATA_W-1:0]   m0_wb_i_dat,
  output logic                   m0_wb_ack,
  output logic                   m0_wb_err,
  input  logic                   m1_wb_cyc,
  input  logic                   m1_wb_stb,
  input  logic                   m1_wb_we,
  input  logic [WB_ADDR_W-1:0]   m1_wb_adr,
  input  logic [WB_DATA_W-1:0]   m1_wb_o_dat,
  input  logic [WB_SEL_BITS-1:0] m1_wb_sel,
  input  logic                   m1_wb_4_burst,
  input  logic                   m1_wb_8_burst,
  output logic [WB_DATA_W-1:0]   m1_wb_i_dat,
  output logic                   m1_wb_ack,
  output logic                   m1_wb_err,
  output logic                   s_wb_cyc,
  output logic                   s_wb_stb,
  output logic                   s_wb_we,
  output logic [WB_ADDR_W-1:0]   s_wb_adr,
  output logic [WB_DATA_W-1:0]   s_wb_o_dat,
  output logic [WB_SEL_BITS-1:0] s_wb_sel,
  output logic                   s_wb_4_burst,
  output logic                   s_wb_8_burst,
  input  logic [WB_DATA_W-1:0]   s_wb_i_dat,
  input  logic                   s_wb_ack,
  input  logic                   s_wb_err,
  output logic [1:0]             o_grant,
  output logic                   o_timeout
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  localparam logic [7:0] WDT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       last_grant;  // index of the master granted most recently
  logic [7:0] wdt;
  logic       gnt_stb;
  logic       stalled;
  logic       wdt_expire;

  // Taken from the masters directly so the watchdog does not loop through the routing block.
  assign gnt_stb    = ((state == GNT0) && m0_wb_stb) || ((state == GNT1) && m1_wb_stb);
  assign stalled    = gnt_stb && !s_wb_ack && !s_wb_err;
  assign wdt_expire = stalled && (wdt == WDT_LAST);

  always_ff @(posedge i_clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      wdt        <= 8'd0;
      o_timeout  <= 1'b0;
    end else begin
      if (wdt_expire) o_timeout <= 1'b1;
      wdt <= (stalled && !wdt_expire) ? wdt + 8'd1 : 8'd0;
      unique case (state)
        IDLE: begin
          // With both requesting, m0 wins only when m1 was served last.
          if (m0_wb_cyc && (!m1_wb_cyc || last_grant)) begin
            state      <= GNT0;
            last_grant <= 1'b0;
          end else if (m1_wb_cyc) begin
            state      <= GNT1;
            last_grant <= 1'b1;
          end
        end
        GNT0:    if (!m0_wb_cyc) state <= IDLE;
        GNT1:    if (!m1_wb_cyc) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: every routed output is defaulted first so no branch can infer a latch.
    s_wb_cyc     = 1'b0;
    s_wb_stb     = 1'b0;
    s_wb_we      = 1'b0;
    s_wb_4_burst = 1'b0;
    s_wb_8_burst = 1'b0;
    s_wb_adr     = m0_wb_adr;
    s_wb_o_dat   = m0_wb_o_dat;
    s_wb_sel     = m0_wb_sel;
    m0_wb_ack    = 1'b0;
    m0_wb_err    = 1'b0;
    m1_wb_ack    = 1'b0;
    m1_wb_err    = 1'b0;
    unique case (state)
      GNT0: begin
        s_wb_cyc     = m0_wb_cyc;
        s_wb_stb     = m0_wb_stb;
        s_wb_we      = m0_wb_we;
        s_wb_4_burst = m0_wb_4_burst;
        s_wb_8_burst = m0_wb_8_burst;
        m0_wb_ack    = s_wb_ack;
        m0_wb_err    = s_wb_err | wdt_expire;
      end
      GNT1: begin
        s_wb_cyc     = m1_wb_cyc;
        s_wb_stb     = m1_wb_stb;
        s_wb_we      = m1_wb_we;
        s_wb_adr     = m1_wb_adr;
        s_wb_o_dat   = m1_wb_o_dat;
        s_wb_sel     = m1_wb_sel;
        s_wb_4_burst = m1_wb_4_burst;
        s_wb_8_burst = m1_wb_8_burst;
        m1_wb_ack    = s_wb_ack;
        m1_wb_err    = s_wb_err | wdt_expire;
      end
      default: ;
    endcase
  end

  assign m0_wb_i_dat = s_wb_i_dat;
  assign m1_wb_i_dat = s_wb_i_dat;
  assign o_grant     = {state == GNT1, state == GNT0};

endmodule

// File: tb/tb_wb_cw_arbiter.sv
// Bench for wb_cw_arbiter: directed scenarios then random traffic, all compared each cycle
// against a reference model of the arbitration, routing and watchdog rules.
module tb_wb_cw_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int SW = 2;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          m0_wb_cyc, m0_wb_stb, m0_wb_we, m0_wb_4_burst, m0_wb_8_burst;
  logic [AW-1:0] m0_wb_adr;
  logic [DW-1:0] m0_wb_o_dat, m0_wb_i_dat;
  logic [SW-1:0] m0_wb_sel;
  logic          m0_wb_ack, m0_wb_err;
  logic          m1_wb_cyc, m1_wb_stb, m1_wb_we, m1_wb_4_burst, m1_wb_8_burst;
  logic [AW-1:0] m1_wb_adr;
  logic [DW-1:0] m1_wb_o_dat, m1_wb_i_dat;
  logic [SW-1:0] m1_wb_sel;
  logic          m1_wb_ack, m1_wb_err;
  logic          s_wb_cyc, s_wb_stb, s_wb_we, s_wb_4_burst, s_wb_8_burst;
  logic [AW-1:0] s_wb_adr;
  logic [DW-1:0] s_wb_o_dat, s_wb_i_dat;
  logic [SW-1:0] s_wb_sel;
  logic          s_wb_ack, s_wb_err;
  logic [1:0]    o_grant;
  logic          o_timeout;

  wb_cw_arbiter #(
    .WB_ADDR_W(AW), .WB_DATA_W(DW), .WB_SEL_BITS(SW), .TIMEOUT(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .m0_wb_cyc(m0_wb_cyc), .m0_wb_stb(m0_wb_stb), .m0_wb_we(m0_wb_we),
    .m0_wb_adr(m0_wb_adr), .m0_wb_o_dat(m0_wb_o_dat), .m0_wb_sel(m0_wb_sel),
    .m0_wb_4_burst(m0_wb_4_burst), .m0_wb_8_burst(m0_wb_8_burst),
    .m0_wb_i_dat(m0_wb_i_dat), .m0_wb_ack(m0_wb_ack), .m0_wb_err(m0_wb_err),
    .m1_wb_cyc(m1_wb_cyc), .m1_wb_stb(m1_wb_stb), .m1_wb_we(m1_wb_we),
    .m1_wb_adr(m1_wb_adr), .m1_wb_o_dat(m1_wb_o_dat), .m1_wb_sel(m1_wb_sel),
    .m1_wb_4_burst(m1_wb_4_burst), .m1_wb_8_burst(m1_wb_8_burst),
    .m1_wb_i_dat(m1_wb_i_dat), .m1_wb_ack(m1_wb_ack), .m1_wb_err(m1_wb_err),
    .s_wb_cyc(s_wb_cyc), .s_wb_stb(s_wb_stb), .s_wb_we(s_wb_we),
    .s_wb_adr(s_wb_adr), .s_wb_o_dat(s_wb_o_dat), .s_wb_sel(s_wb_sel),
    .s_wb_4_burst(s_wb_4_burst), .s_wb_8_burst(s_wb_8_burst),
    .s_wb_i_dat(s_wb_i_dat), .s_wb_ack(s_wb_ack), .s_wb_err(s_wb_err),
    .o_grant(o_grant), .o_timeout(o_timeout)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Reference model: owner 0 = nobody, 1 = m0, 2 = m1; run = consecutive stalled beats.
  int owner, last, run;
  bit sticky;

  // Observed-event bookkeeping for scenario-level checks.
  int         gq[$];
  logic [1:0] prev_g = 2'b00;
  int         n_ack0 = 0, n_ack1 = 0, n_err0 = 0, n_err1 = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner  = 0;
    last   = 2;
    run    = 0;
    sticky = 1'b0;
  endtask

  // One clock: compare mid-cycle at the falling edge, then advance the model on the rising edge.
  task automatic cycle();
    logic [4:0]    ctl;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    logic [3:0]    term;
    logic [1:0]    g;
    bit            stalled, expire;
    @(negedge clk);
    adr = m0_wb_adr;
    dat = m0_wb_o_dat;
    sel = m0_wb_sel;
    ctl = 5'b0;
    if (owner == 1) begin
      ctl = {m0_wb_cyc, m0_wb_stb, m0_wb_we, m0_wb_4_burst, m0_wb_8_burst};
    end else if (owner == 2) begin
      ctl = {m1_wb_cyc, m1_wb_stb, m1_wb_we, m1_wb_4_burst, m1_wb_8_burst};
      adr = m1_wb_adr;
      dat = m1_wb_o_dat;
      sel = m1_wb_sel;
    end
    stalled = (owner != 0) && ctl[3] && !s_wb_ack && !s_wb_err;
    expire  = stalled && ((run + 1) % TO == 0);
    term = 4'b0;
    if (owner == 1) term = {s_wb_ack, s_wb_err | expire, 2'b00};
    if (owner == 2) term = {2'b00, s_wb_ack, s_wb_err | expire};
    g = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;

    check("grant", o_grant, g);
    check("s_ctl", {s_wb_cyc, s_wb_stb, s_wb_we, s_wb_4_burst, s_wb_8_burst}, ctl);
    check("s_adr", s_wb_adr, adr);
    check("s_dat", s_wb_o_dat, dat);
    check("s_sel", s_wb_sel, sel);
    check("m_term", {m0_wb_ack, m0_wb_err, m1_wb_ack, m1_wb_err}, term);
    check("rdat", {m0_wb_i_dat, m1_wb_i_dat}, {s_wb_i_dat, s_wb_i_dat});
    check("timeout", o_timeout, sticky);

    if (o_grant != 2'b00 && prev_g == 2'b00) gq.push_back(int'(o_grant));
    prev_g = o_grant;
    n_ack0 += int'(m0_wb_ack);
    n_ack1 += int'(m1_wb_ack);
    n_err0 += int'(m0_wb_err);
    n_err1 += int'(m1_wb_err);

    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (expire) sticky = 1'b1;
      run = stalled ? run + 1 : 0;
      if (owner == 0) begin
        if (m0_wb_cyc && m1_wb_cyc) owner = (last == 1) ? 2 : 1;
        else if (m0_wb_cyc)         owner = 1;
        else if (m1_wb_cyc)         owner = 2;
        if (owner != 0) last = owner;
      end else if ((owner == 1 && !m0_wb_cyc) || (owner == 2 && !m1_wb_cyc)) begin
        owner = 0;
      end
    end
    #1;
  endtask

  task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                       input logic [SW-1:0] sel, input logic b4, input logic b8);
    if (m == 0) begin
      m0_wb_cyc = cyc; m0_wb_stb = stb; m0_wb_we = we; m0_wb_adr = adr;
      m0_wb_o_dat = dat; m0_wb_sel = sel; m0_wb_4_burst = b4; m0_wb_8_burst = b8;
    end else begin
      m1_wb_cyc = cyc; m1_wb_stb = stb; m1_wb_we = we; m1_wb_adr = adr;
      m1_wb_o_dat = dat; m1_wb_sel = sel; m1_wb_4_burst = b4; m1_wb_8_burst = b8;
    end
  endtask

  task automatic drop(input int m);
    set_m(m, 1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "time budget exceeded");
  end

  initial begin
    int a1, e0, e1;
    bit quiet;
    rst = 1'b1;
    drop(0);
    drop(1);
    s_wb_ack = 1'b0; s_wb_err = 1'b0; s_wb_i_dat = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state, held in reset and the cycle after.
    cycle();
    rst = 1'b0;
    cycle();

    // Single m0 read, slave acks with 0xBEEF three cycles after s_wb_cyc.
    set_m(0, 1'b1, 1'b1, 1'b0, 24'h001000, 16'h0, 2'b11, 1'b0, 1'b0);
    cycle();
    repeat (3) cycle();
    s_wb_ack = 1'b1; s_wb_i_dat = 16'hBEEF;
    cycle();
    s_wb_ack = 1'b0;
    drop(0);
    cycle();
    cycle();

    // Contention after reset: three back-to-back simultaneous requests.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    gq.delete();
    a1 = n_ack1;
    for (int r = 0; r < 3; r++) begin
      set_m(0, 1'b1, 1'b1, 1'b0, 24'h000100 + 24'(r), 16'h1111, 2'b01, 1'b0, 1'b0);
      set_m(1, 1'b1, 1'b1, 1'b1, 24'h000200 + 24'(r), 16'h2222, 2'b10, 1'b0, 1'b0);
      cycle();
      s_wb_ack = 1'b1; s_wb_i_dat = 16'(r);
      cycle();
      s_wb_ack = 1'b0;
      if (o_grant[0]) drop(0);
      else drop(1);
      cycle();
    end
    drop(1);
    cycle();
    check("rr_count", gq.size(), 3);
    if (gq.size() == 3) begin
      check("rr_first", gq[0], 1);
      check("rr_second", gq[1], 2);
      check("rr_third", gq[2], 1);
    end
    check("rr_m1_acks", n_ack1 - a1, 1);

    // 8-beat burst on m1, m0 requests mid-burst.
    gq.delete();
    set_m(1, 1'b1, 1'b1, 1'b0, 24'h004000, 16'h0, 2'b11, 1'b0, 1'b1);
    cycle();
    a1 = n_ack1;
    e0 = n_ack0;
    for (int b = 0; b < 8; b++) begin
      s_wb_ack = 1'b1;
      s_wb_i_dat = 16'hA000 + 16'(b);
      m1_wb_adr = 24'h004000 + 24'(b);
      if (b == 3) set_m(0, 1'b1, 1'b1, 1'b1, 24'h005000, 16'h5A5A, 2'b11, 1'b0, 1'b0);
      cycle();
    end
    check("burst_m1_acks", n_ack1 - a1, 8);
    check("burst_m0_acks", n_ack0 - e0, 0);
    s_wb_ack = 1'b0;
    drop(1);
    cycle();
    cycle();
    s_wb_ack = 1'b1;
    cycle();
    s_wb_ack = 1'b0;
    drop(0);
    cycle();
    check("burst_order_n", gq.size(), 2);
    if (gq.size() == 2) check("burst_then_m0", gq[1], 1);

    // Watchdog: m0 strobes, slave silent for nine beats, then a normal ack.
    e0 = n_err0;
    set_m(0, 1'b1, 1'b1, 1'b0, 24'h00ABCD, 16'h0, 2'b11, 1'b0, 1'b0);
    cycle();
    repeat (9) cycle();
    check("wdt_err_pulses", n_err0 - e0, 2);
    check("wdt_sticky", o_timeout, 1'b1);
    s_wb_ack = 1'b1;
    cycle();
    s_wb_ack = 1'b0;
    drop(0);
    cycle();
    cycle();
    check("wdt_sticky_hold", o_timeout, 1'b1);

    // Reset during beat 3 of an m0 4-beat burst; m0 wins the next contention.
    gq.delete();
    set_m(0, 1'b1, 1'b1, 1'b0, 24'h007000, 16'h0, 2'b11, 1'b1, 1'b0);
    cycle();
    s_wb_ack = 1'b1;
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    s_wb_ack = 1'b0;
    check("rst_idle", {s_wb_cyc, o_grant}, 3'b000);
    set_m(1, 1'b1, 1'b1, 1'b0, 24'h008000, 16'h0, 2'b01, 1'b0, 1'b0);
    gq.delete();
    cycle();
    s_wb_ack = 1'b1;
    cycle();
    s_wb_ack = 1'b0;
    drop(0);
    drop(1);
    cycle();
    cycle();
    check("rst_next_grant_n", gq.size(), 1);
    if (gq.size() == 1) check("rst_next_grant", gq[0], 1);

    // Slave err passthrough on an m1 write.
    e1 = n_err1;
    set_m(1, 1'b1, 1'b1, 1'b1, 24'h00C0DE, 16'hCAFE, 2'b11, 1'b0, 1'b0);
    cycle();
    s_wb_err = 1'b1;
    cycle();
    s_wb_err = 1'b0;
    drop(1);
    cycle();
    cycle();
    check("err_pulses", n_err1 - e1, 1);
    check("err_no_timeout", o_timeout, 1'b0);

    // Random traffic with occasional silent-slave stretches and resets.
    quiet = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) quiet = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 299) == 0);
      if (!m0_wb_cyc) m0_wb_cyc = ($urandom_range(0, 3) == 0);
      else            m0_wb_cyc = ($urandom_range(0, 7) != 0);
      if (!m1_wb_cyc) m1_wb_cyc = ($urandom_range(0, 3) == 0);
      else            m1_wb_cyc = ($urandom_range(0, 7) != 0);
      m0_wb_stb = ($urandom_range(0, 3) != 0);
      m1_wb_stb = ($urandom_range(0, 3) != 0);
      m0_wb_we = 1'($urandom); m1_wb_we = 1'($urandom);
      m0_wb_adr = AW'($urandom); m1_wb_adr = AW'($urandom);
      m0_wb_o_dat = DW'($urandom); m1_wb_o_dat = DW'($urandom);
      m0_wb_sel = SW'($urandom); m1_wb_sel = SW'($urandom);
      m0_wb_4_burst = 1'($urandom); m0_wb_8_burst = 1'($urandom);
      m1_wb_4_burst = 1'($urandom); m1_wb_8_burst = 1'($urandom);
      s_wb_ack = quiet ? 1'b0 : ($urandom_range(0, 2) == 0);
      s_wb_err = quiet ? 1'b0 : ($urandom_range(0, 19) == 0);
      s_wb_i_dat = DW'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
